x_dl_capture_ctrl: RTL and testbench



---
 rtl/x_dl_pkg.sv | 53 +++++
 rtl/x_dl_edge_find.sv | 31 +++
 rtl/x_dl_capture_ctrl.sv | 174 +++++++++++++++++
 tb/tb_x_dl_capture_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/x_dl_pkg.sv
// x_dl_pkg: shared types and constants for the delay-line capture controller.
//   t_cap_state   : capture sequencer states
//   DL_WIDTH      : delay-line snapshot width
//   EDGE_W        : edge-index width (0..256)
//   EDGE_NONE     : edge index reported when the snapshot has no transition
//   RESULT_TAG    : tag byte placed at the top of a statistics result
//   RES_*_LSB     : field offsets inside the packed 256-bit result word
//   pack_result() : assembles the statistics result word
package x_dl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WAIT   = 3'd1,
        ST_SAMPLE = 3'd2,
        ST_ACCUM  = 3'd3,
        ST_DONE   = 3'd4
    } t_cap_state;

    localparam int          DL_WIDTH   = 256;
    localparam int          EDGE_W     = 9;
    localparam logic [8:0]  EDGE_NONE  = 9'd256;
    localparam logic [8:0]  MIN_INIT   = 9'h1FF;
    localparam logic [7:0]  RESULT_TAG = 8'hA5;
    localparam int          SUM_W      = 24;
    localparam int          CNT_W      = 16;
    localparam int          IVL_W      = 20;

    localparam int RES_MIN_LSB  = 0;
    localparam int RES_MAX_LSB  = 16;
    localparam int RES_SUM_LSB  = 32;
    localparam int RES_CNT_LSB  = 64;
    localparam int RES_MISS_LSB = 80;
    localparam int RES_TAG_LSB  = 248;

    function automatic logic [DL_WIDTH-1:0] pack_result(
        input logic [EDGE_W-1:0] min_v,
        input logic [EDGE_W-1:0] max_v,
        input logic [SUM_W-1:0]  sum_v,
        input logic [CNT_W-1:0]  count_v,
        input logic [CNT_W-1:0]  miss_v
    );
        logic [DL_WIDTH-1:0] w;
        w = '0;
        w[RES_MIN_LSB  +: EDGE_W] = min_v;
        w[RES_MAX_LSB  +: EDGE_W] = max_v;
        w[RES_SUM_LSB  +: SUM_W]  = sum_v;
        w[RES_CNT_LSB  +: CNT_W]  = count_v;
        w[RES_MISS_LSB +: CNT_W]  = miss_v;
        w[RES_TAG_LSB  +: 8]      = RESULT_TAG;
        return w;
    endfunction

endpackage

// File: rtl/x_dl_edge_find.sv
// x_dl_edge_find: combinational thermometer-edge locator.
//   data_i [255:0] : delay-line snapshot
//   edge_o [8:0]   : smallest index i in 1..255 with data_i[i] != data_i[0],
//                    or 256 when every bit equals bit 0
module x_dl_edge_find
    import x_dl_pkg::*;
(
    input  logic [DL_WIDTH-1:0] data_i,
    output logic [EDGE_W-1:0]   edge_o
);

    // Bit i differs from the reference bit 0; polarity of the line does not matter.
    logic [DL_WIDTH-1:1] diff;

    generate
        for (genvar gi = 1; gi < DL_WIDTH; gi++) begin : g_diff
            assign diff[gi] = data_i[gi] ^ data_i[0];
        end
    endgenerate

    // Scan from the top down so the lowest differing bit wins.
    always_comb begin
        edge_o = EDGE_NONE;
        for (int i = DL_WIDTH - 1; i >= 1; i--) begin
            if (diff[i]) begin
                edge_o = EDGE_W'(i);
            end
        end
    end

endmodule

// File: rtl/x_dl_capture_ctrl.sv
// x_dl_capture_ctrl: sequences calibration captures of the delay-line snapshot
// and reports min/max/sum/count/miss edge statistics as one 256-bit word.
//   i_clk    : system clock (also the delay-line sample clock)
//   i_nrst   : synchronous active-low reset
//   i_start  : single-cycle run request, honoured only in IDLE
//   i_data   : registered delay-line snapshot
//   o_busy   : high from run accept until the result handshake completes
//   o_valid  : result word available
//   i_ready  : consumer accepts the result with o_valid
//   o_result : packed statistics word (or raw snapshot on a raw run)
// Optional build macro X_DL_CAP_RAW_EN adds i_raw: a run started with i_raw=1
// takes one snapshot after one WAIT period and returns it unmodified.
module x_dl_capture_ctrl
    import x_dl_pkg::*;
#(
    parameter int p_width    = 256,
    parameter int p_samples  = 64,
    parameter int p_interval = 1000
) (
    input  logic               i_clk,
    input  logic               i_nrst,
    input  logic               i_start,
`ifdef X_DL_CAP_RAW_EN
    input  logic               i_raw,
`endif
    input  logic [p_width-1:0] i_data,
    output logic               o_busy,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [p_width-1:0] o_result
);

    localparam logic [CNT_W-1:0] SAMPLES_N   = CNT_W'(p_samples);
    localparam logic [IVL_W-1:0] INTERVAL_M1 = IVL_W'(p_interval - 1);

    t_cap_state         state_q, state_d;
    logic [IVL_W-1:0]   ivl_q,   ivl_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [CNT_W-1:0]   miss_q,  miss_d;
    logic [SUM_W-1:0]   sum_q,   sum_d;
    logic [EDGE_W-1:0]  min_q,   min_d;
    logic [EDGE_W-1:0]  max_q,   max_d;
    logic [p_width-1:0] cap_q,   cap_d;
    logic [EDGE_W-1:0]  edge_idx;
    logic               raw_run;
`ifdef X_DL_CAP_RAW_EN
    logic               raw_q,   raw_d;
    assign raw_run = raw_q;
`else
    assign raw_run = 1'b0;
`endif

    x_dl_edge_find u_edge_find (
        .data_i (cap_q),
        .edge_o (edge_idx)
    );

    // State and datapath registers.
    always_ff @(posedge i_clk) begin
        if (!i_nrst) begin
            state_q <= ST_IDLE;
            ivl_q   <= '0;
            count_q <= '0;
            miss_q  <= '0;
            sum_q   <= '0;
            min_q   <= MIN_INIT;
            max_q   <= '0;
            cap_q   <= '0;
`ifdef X_DL_CAP_RAW_EN
            raw_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ivl_q   <= ivl_d;
            count_q <= count_d;
            miss_q  <= miss_d;
            sum_q   <= sum_d;
            min_q   <= min_d;
            max_q   <= max_d;
            cap_q   <= cap_d;
`ifdef X_DL_CAP_RAW_EN
            raw_q   <= raw_d;
`endif
        end
    end

    // Next-state and datapath updates.
    always_comb begin
        state_d = state_q;
        ivl_d   = ivl_q;
        count_d = count_q;
        miss_d  = miss_q;
        sum_d   = sum_q;
        min_d   = min_q;
        max_d   = max_q;
        cap_d   = cap_q;
`ifdef X_DL_CAP_RAW_EN
        raw_d   = raw_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    state_d = ST_WAIT;
                    ivl_d   = INTERVAL_M1;
                    count_d = '0;
                    miss_d  = '0;
                    sum_d   = '0;
                    min_d   = MIN_INIT;
                    max_d   = '0;
`ifdef X_DL_CAP_RAW_EN
                    raw_d   = i_raw;
`endif
                end
            end
            ST_WAIT: begin
                // Loaded with p_interval-1, so WAIT lasts exactly p_interval cycles.
                if (ivl_q == '0) begin
                    state_d = ST_SAMPLE;
                end else begin
                    ivl_d = ivl_q - 1'b1;
                end
            end
            ST_SAMPLE: begin
                cap_d   = i_data;
                state_d = raw_run ? ST_DONE : ST_ACCUM;
            end
            ST_ACCUM: begin
                if (edge_idx == EDGE_NONE) begin
                    miss_d = miss_q + 1'b1;
                end else begin
                    sum_d = sum_q + SUM_W'(edge_idx);
                    if (edge_idx < min_q) begin
                        min_d = edge_idx;
                    end
                    if (edge_idx > max_q) begin
                        max_d = edge_idx;
                    end
                end
                count_d = count_q + 1'b1;
                if (count_d == SAMPLES_N) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_WAIT;
                    ivl_d   = INTERVAL_M1;
                end
            end
            ST_DONE: begin
                // i_start is deliberately not looked at here: a new run needs
                // a fresh pulse once back in IDLE.
                if (i_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs decoded from the current state; the result is zero outside DONE.
    always_comb begin
        o_busy   = (state_q != ST_IDLE);
        o_valid  = (state_q == ST_DONE);
        o_result = '0;
        if (state_q == ST_DONE) begin
            if (raw_run) begin
                o_result = cap_q;
            end else begin
                o_result = pack_result(min_q, max_q, sum_q, count_q, miss_q);
            end
        end
    end

endmodule

// File: tb/tb_x_dl_capture_ctrl.sv
module tb_x_dl_capture_ctrl;

    localparam int P_S  = 4;
    localparam int P_I  = 3;
    localparam int LAT  = P_S * (P_I + 2) + 1;
    localparam int P_S2 = 2;
    localparam int P_I2 = 1;
    localparam int LAT2 = P_S2 * (P_I2 + 2) + 1;

    logic         clk = 1'b0;
    logic         nrst;
    logic         i_start;
    logic [255:0] i_data;
    logic         o_busy;
    logic         o_valid;
    logic         i_ready;
    logic [255:0] o_result;

    logic         start2;
    logic         ready2;
    logic         busy2;
    logic         valid2;
    logic [255:0] result2;

    int n_checks = 0;
    int n_errors = 0;

    logic [255:0] sb[$];

    always #5 clk = ~clk;

    x_dl_capture_ctrl #(
        .p_width    (256),
        .p_samples  (P_S),
        .p_interval (P_I)
    ) dut (
        .i_clk    (clk),
        .i_nrst   (nrst),
        .i_start  (i_start),
        .i_data   (i_data),
        .o_busy   (o_busy),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_result (o_result)
    );

    x_dl_capture_ctrl #(
        .p_width    (256),
        .p_samples  (P_S2),
        .p_interval (P_I2)
    ) dut2 (
        .i_clk    (clk),
        .i_nrst   (nrst),
        .i_start  (start2),
        .i_data   (i_data),
        .o_busy   (busy2),
        .o_valid  (valid2),
        .i_ready  (ready2),
        .o_result (result2)
    );

    typedef struct {
        logic [3:0][8:0] edges;
        bit              inv;
        logic [8:0]      exp_min;
        logic [8:0]      exp_max;
        logic [23:0]     exp_sum;
        logic [15:0]     exp_miss;
    } vec_t;

    vec_t tbl[5];

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Snapshot whose first transition away from bit 0 sits at index e (256 = none).
    function automatic logic [255:0] snap(input logic [8:0] e, input bit inv);
        logic [255:0] ones;
        logic [255:0] d;
        ones = '1;
        if (e == 9'd256) d = ones;
        else             d = ones << e;
        return inv ? ~d : d;
    endfunction

    function automatic logic [255:0] pack_exp(input logic [8:0] mn, input logic [8:0] mx,
                                              input logic [23:0] sm, input logic [15:0] cnt,
                                              input logic [15:0] ms);
        logic [255:0] w;
        w = '0;
        w[8:0]     = mn;
        w[24:16]   = mx;
        w[55:32]   = sm;
        w[79:64]   = cnt;
        w[95:80]   = ms;
        w[255:248] = 8'hA5;
        return w;
    endfunction

    function automatic vec_t mk(input logic [8:0] e0, input logic [8:0] e1, input logic [8:0] e2,
                                input logic [8:0] e3, input bit inv, input logic [8:0] mn,
                                input logic [8:0] mx, input logic [23:0] sm, input logic [15:0] ms);
        vec_t v;
        v.edges    = {e3, e2, e1, e0};
        v.inv      = inv;
        v.exp_min  = mn;
        v.exp_max  = mx;
        v.exp_sum  = sm;
        v.exp_miss = ms;
        return v;
    endfunction

    // Scoreboard consumer: every accepted result is compared with the oldest expectation.
    always @(negedge clk) begin
        if (nrst && o_valid && i_ready) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL sb_unexpected: got result %h, expected none", o_result);
            end else begin
                check("sb_result", o_result, sb.pop_front());
            end
        end
    end

    task automatic run_vec(input int idx, input bit hold, input bit noise);
        logic [255:0] exp_w;
        vec_t v;
        v = tbl[idx];
        exp_w = pack_exp(v.exp_min, v.exp_max, v.exp_sum, 16'(P_S), v.exp_miss);
        i_data = snap(v.edges[0], v.inv);
        @(posedge clk); #1;
        i_start = 1'b1;
        i_ready = !hold;
        sb.push_back(exp_w);
        for (int n = 1; n <= LAT; n++) begin
            @(posedge clk); #1;
            i_start = 1'b0;
            if (noise && (n == 8 || n == 13)) i_start = 1'b1;
            for (int k = 0; k < P_S - 1; k++) begin
                if (n == (k + 1) * (P_I + 2)) i_data = snap(v.edges[k + 1], v.inv);
            end
            if (n == LAT - 1) check("valid_before_latency", 256'(o_valid), 256'(0));
            if (n == LAT) begin
                check("valid_at_latency", 256'(o_valid), 256'(1));
                check("busy_at_latency", 256'(o_busy), 256'(1));
            end
        end
        if (hold) begin
            for (int c = 0; c < 50; c++) begin
                @(posedge clk); #1;
                check("hold_valid", 256'(o_valid), 256'(1));
                check("hold_result", o_result, exp_w);
            end
            i_ready = 1'b1;
            i_start = 1'b1;
            @(posedge clk); #1;
            i_start = 1'b0;
        end else begin
            @(posedge clk); #1;
        end
        $display("run %0d: result handshake done, expected %h", idx, exp_w);
        check("post_hs_busy", 256'(o_busy), 256'(0));
        check("post_hs_valid", 256'(o_valid), 256'(0));
        check("post_hs_result", o_result, 256'(0));
        repeat (3) @(posedge clk);
        #1;
        check("idle_after_hs", 256'(o_busy), 256'(0));
        i_ready = 1'b1;
    endtask

    initial begin
        bit idle_bad;

        tbl[0] = mk(9'd16, 9'd16, 9'd16, 9'd16, 1'b0, 9'd16, 9'd16, 24'd64, 16'd0);
        tbl[1] = mk(9'd10, 9'd20, 9'd30, 9'd40, 1'b0, 9'd10, 9'd40, 24'd100, 16'd0);
        tbl[2] = mk(9'd256, 9'd256, 9'd256, 9'd256, 1'b0, 9'h1FF, 9'd0, 24'd0, 16'd4);
        tbl[3] = mk(9'd1, 9'd255, 9'd256, 9'd128, 1'b1, 9'd1, 9'd255, 24'd384, 16'd1);
        tbl[4] = mk(9'd200, 9'd5, 9'd256, 9'd256, 1'b0, 9'd5, 9'd200, 24'd205, 16'd2);

        nrst    = 1'b0;
        i_start = 1'b0;
        i_ready = 1'b1;
        i_data  = '0;
        start2  = 1'b0;
        ready2  = 1'b1;

        // Reset and idle.
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 256'(o_valid), 256'(0));
        check("rst_busy", 256'(o_busy), 256'(0));
        check("rst_result", o_result, 256'(0));
        nrst = 1'b1;
        idle_bad = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(posedge clk); #1;
            if (o_busy || o_valid || (o_result != '0)) idle_bad = 1'b1;
        end
        check("idle_100", 256'(idle_bad), 256'(0));
        $display("reset/idle sequence done");

        // Table-driven runs; run 1 also exercises backpressure and ignored start pulses.
        for (int i = 0; i < 5; i++) begin
            run_vec(i, (i == 1), (i == 1));
        end

        // Reset during the second WAIT aborts with no result emitted.
        i_data = snap(9'd16, 1'b0);
        @(posedge clk); #1;
        i_start = 1'b1;
        for (int n = 1; n <= 7; n++) begin
            @(posedge clk); #1;
            i_start = 1'b0;
        end
        nrst = 1'b0;
        @(posedge clk); #1;
        check("abort_busy", 256'(o_busy), 256'(0));
        check("abort_valid", 256'(o_valid), 256'(0));
        check("abort_result", o_result, 256'(0));
        nrst = 1'b1;
        $display("mid-run reset done");
        run_vec(0, 1'b0, 1'b0);

        // One-cycle WAIT instance.
        i_data = snap(9'd16, 1'b0);
        @(posedge clk); #1;
        start2 = 1'b1;
        for (int n = 1; n <= LAT2; n++) begin
            @(posedge clk); #1;
            start2 = 1'b0;
            if (n == LAT2 - 1) check("i1_valid_early", 256'(valid2), 256'(0));
            if (n == LAT2) begin
                check("i1_valid", 256'(valid2), 256'(1));
                check("i1_result", result2, pack_exp(9'd16, 9'd16, 24'd32, 16'd2, 16'd0));
            end
        end
        @(posedge clk); #1;
        check("i1_post_valid", 256'(valid2), 256'(0));
        check("i1_post_busy", 256'(busy2), 256'(0));
        $display("interval=1 run done");

        check("sb_empty", 256'(sb.size()), 256'(0));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
